// File: rtl/sdram_p2_arbiter.sv
// sdram_p2_arbiter
//   Shares the SDRAM controller's second port (p2) between NUM_REQ requesters.
//   The arbiter grants one requester at a time in round-robin order and latches
//   that request onto p2_*. It holds p2_cs until the controller's p2_ack toggle
//   flips, then pulses req_ack for the granted requester. Read data is returned
//   on req_dout.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     Adds a WAIT watchdog. If TIMEOUT cycles pass without an ack toggle, the
//     transaction is completed with req_ack and req_err pulsed together.
//     When the macro is undefined, req_err is tied to 0.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   req/req_we            per-requester request level / write enable
//   req_addr/din/ds       packed per-requester fields (22/16/2 bits each)
//   req_ack/req_err       one-cycle completion / timeout pulses
//   req_dout              read data of the last completed read
//   p2_cs/we/addr/din/ds  request fields presented to the controller
//   p2_dout/p2_ack        controller read data / completion toggle
module sdram_p2_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [22*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]   req_din,
  input  logic [2*NUM_REQ-1:0]    req_ds,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [15:0]             req_dout,
  output logic                    p2_cs,
  output logic                    p2_we,
  output logic [21:0]             p2_addr,
  output logic [15:0]             p2_din,
  output logic [1:0]              p2_ds,
  input  logic [15:0]             p2_dout,
  input  logic                    p2_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] NREQ = 3'(NUM_REQ);
  localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 ack_ref_q, ack_ref_d;
  logic                 cs_q, cs_d;
  logic                 we_q, we_d;
  logic [21:0]          addr_q, addr_d;
  logic [15:0]          din_q, din_d;
  logic [1:0]           ds_q, ds_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [15:0]          dout_q, dout_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
`endif

  logic [3:0]  req_pad;
  logic [2:0]  cand;
  logic [1:0]  win;
  logic        win_vld;
  logic        sel_we;
  logic [21:0] sel_addr;
  logic [15:0] sel_din;
  logic [1:0]  sel_ds;
  logic [3:0]  owner_1h;
  logic        toggled;

  // The round-robin search starts at ptr+1 and wraps. Because ptr < NUM_REQ
  // and k <= NUM_REQ, one conditional subtract replaces the modulo.
  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
    win                  = ptr_q;
    win_vld              = 1'b0;
    cand                 = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + k[2:0];
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!win_vld && req_pad[cand[1:0]]) begin
        win_vld = 1'b1;
        win     = cand[1:0];
      end
    end
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    sel_ds   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == i[1:0]) begin
        sel_we   = req_we[i];
        sel_addr = req_addr[22*i +: 22];
        sel_din  = req_din[16*i +: 16];
        sel_ds   = req_ds[2*i +: 2];
      end
    end
  end

  // The pointer holds the current owner for the whole transaction.
  assign owner_1h = 4'b0001 << ptr_q;
  assign toggled  = (p2_ack != ack_ref_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ack_ref_d = ack_ref_q;
    cs_d      = cs_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    ds_d      = ds_q;
    ack_d     = '0;
    dout_d    = dout_q;
`ifdef ARB_TIMEOUT_EN
    err_d     = '0;
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d   = S_WAIT;
          ptr_d     = win;
          ack_ref_d = p2_ack;
          cs_d      = 1'b1;
          we_d      = sel_we;
          addr_d    = sel_addr;
          din_d     = sel_din;
          ds_d      = sel_ds;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_WAIT: begin
        if (toggled) begin
          state_d = S_DONE;
          cs_d    = 1'b0;
          ack_d   = owner_1h[NUM_REQ-1:0];
          if (!we_q) begin
            dout_d = p2_dout;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cs_d    = 1'b0;
          ack_d   = owner_1h[NUM_REQ-1:0];
          err_d   = owner_1h[NUM_REQ-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= LAST;
      ack_ref_q <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      ds_q      <= '0;
      ack_q     <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_ref_q <= ack_ref_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      ds_q      <= ds_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign req_err = err_q;
`else
  assign req_err = '0;
`endif

  assign req_ack  = ack_q;
  assign req_dout = dout_q;
  assign p2_cs    = cs_q;
  assign p2_we    = we_q;
  assign p2_addr  = addr_q;
  assign p2_din   = din_q;
  assign p2_ds    = ds_q;

endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// Testbench for sdram_p2_arbiter. The bench keeps a transaction-level
// reference model, drives an emulated SDRAM controller, and uses directed
// tests followed by randomized requester traffic.
module tb_sdram_p2_arbiter;
  localparam int N = 3;
`ifdef ARB_TIMEOUT_EN
  localparam int TO    = 20;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 1023;
  localparam bit TO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_we;
  logic [22*N-1:0] req_addr;
  logic [16*N-1:0] req_din;
  logic [2*N-1:0]  req_ds;
  logic [N-1:0]  req_ack, req_err;
  logic [15:0]   req_dout;
  logic          p2_cs, p2_we;
  logic [21:0]   p2_addr;
  logic [15:0]   p2_din;
  logic [1:0]    p2_ds;
  logic [15:0]   p2_dout;
  logic          p2_ack;

  sdram_p2_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_ds(req_ds), .req_ack(req_ack), .req_err(req_err),
    .req_dout(req_dout), .p2_cs(p2_cs), .p2_we(p2_we), .p2_addr(p2_addr),
    .p2_din(p2_din), .p2_ds(p2_ds), .p2_dout(p2_dout), .p2_ack(p2_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          e_cs, e_we;
  logic [21:0]   e_addr;
  logic [15:0]   e_din, e_dout;
  logic [1:0]    e_ds;
  logic [N-1:0]  e_ack, e_err;
  bit            m_busy, m_rest, m_ref, m_found;
  int            m_last, m_owner, m_wait, m_c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_cs = 0; e_we = 0; e_addr = 0; e_din = 0; e_ds = 0;
      e_ack = 0; e_err = 0; e_dout = 0;
      m_busy = 0; m_rest = 0; m_ref = 0; m_last = N - 1; m_owner = 0; m_wait = 0;
    end else begin
      e_ack = 0;
      e_err = 0;
      if (m_busy) begin
        if (p2_ack != m_ref) begin
          e_cs = 0;
          e_ack[m_owner] = 1'b1;
          if (!e_we) e_dout = p2_dout;
          m_busy = 0;
          m_rest = 1;
        end else begin
          m_wait++;
          if (TO_ON && m_wait == TO) begin
            e_cs = 0;
            e_ack[m_owner] = 1'b1;
            e_err[m_owner] = 1'b1;
            m_busy = 0;
            m_rest = 1;
          end
        end
      end else if (m_rest) begin
        m_rest = 0;
      end else if (req != 0) begin
        m_found = 0;
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (!m_found && req[m_c]) begin
            m_found = 1;
            m_owner = m_c;
          end
        end
        m_last = m_owner;
        e_cs   = 1;
        e_we   = req_we[m_owner];
        e_addr = req_addr[m_owner*22 +: 22];
        e_din  = req_din[m_owner*16 +: 16];
        e_ds   = req_ds[m_owner*2 +: 2];
        m_ref  = p2_ack;
        m_busy = 1;
        m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle", {p2_cs, p2_we, p2_addr, p2_din, p2_ds, req_ack, req_err, req_dout},
                 {e_cs, e_we, e_addr, e_din, e_ds, e_ack, e_err, e_dout});
  end

  // ---------------- environment ----------------
  int  cyc = 0, grant_cyc = 0;
  bit  prev_cs = 0;
  bit  resp_en = 1, resp_fired = 0, fix_dout_en = 0;
  int  resp_cnt = 0, resp_delay = 3;
  logic [15:0] fix_dout = 16'h0;
  bit  rr_on = 0, rand_on = 0;
  int  rr_gap[N];
  int  raise_cyc[N];
  int  skip[N];
  int  ack_log[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (p2_cs && !prev_cs) grant_cyc = cyc;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        ack_log.push_back(i);
        if (rand_on) begin
          for (int j = 0; j < N; j++) begin
            if (j != i && req[j] && raise_cyc[j] < grant_cyc) begin
              skip[j]++;
              total++;
              if (skip[j] > N - 1) begin
                bad++;
                $display("FAIL rr_wait: requester %0d skipped %0d times, limit %0d", j, skip[j], N - 1);
              end
            end
          end
          skip[i] = 0;
        end
      end
    end
    prev_cs = p2_cs;
    // controller emulation: one toggle per p2_cs assertion
    if (!p2_cs) begin
      resp_cnt   = 0;
      resp_fired = 0;
      if (rand_on && $urandom_range(0, 15) == 0) p2_ack = ~p2_ack;
    end else if (resp_en && !resp_fired) begin
      resp_cnt++;
      if (resp_cnt >= resp_delay) begin
        p2_ack     = ~p2_ack;
        p2_dout    = fix_dout_en ? fix_dout : 16'($urandom);
        resp_fired = 1;
        if (rand_on) resp_delay = $urandom_range(1, 8);
      end
    end
    if (rr_on) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          req[i]    = 1'b0;
          rr_gap[i] = 2;
        end else if (!req[i] && rr_gap[i] > 0) begin
          rr_gap[i]--;
          if (rr_gap[i] == 0) req[i] = 1'b1;
        end
      end
    end
    if (rand_on) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && req_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]       = 1'b1;
          raise_cyc[i] = cyc;
        end
      end
      req_we   = 3'($urandom);
      req_addr = 66'({$urandom, $urandom, $urandom});
      req_din  = 48'({$urandom, $urandom});
      req_ds   = 6'($urandom);
    end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (req_ack == '0 && n < 80) begin
      step();
      n++;
    end
    if (req_ack == '0) begin
      total++;
      bad++;
      $display("FAIL %s: no req_ack within %0d cycles, got %b want nonzero", name, n, req_ack);
    end
  endtask

  task automatic drain();
    int n = 0;
    req = '0;
    while (p2_cs && n < 2000) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  int rr_exp[6] = '{0, 1, 2, 0, 1, 2};
  int tcnt;

  initial begin
    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_din = '0; req_ds = '0;
    p2_ack = 1'b0; p2_dout = '0;
    for (int i = 0; i < N; i++) begin
      rr_gap[i] = 0; raise_cyc[i] = 0; skip[i] = 0;
    end
    repeat (3) step();
    chk("reset_cs", 64'(p2_cs), 64'(0));
    chk("reset_ack", 64'(req_ack), 64'(0));
    chk("reset_dout", 64'(req_dout), 64'(0));
    reset = 1'b0;
    repeat (2) step();

    // single read from requester 1
    resp_delay = 6; fix_dout_en = 1; fix_dout = 16'hBEEF;
    req_addr[22 +: 22] = 22'h012345;
    req_we[1] = 1'b0;
    req = 3'b010;
    step();
    chk("rd_cs", 64'(p2_cs), 64'(1));
    chk("rd_addr", 64'(p2_addr), 64'(22'h012345));
    chk("rd_we", 64'(p2_we), 64'(0));
    wait_ack("rd_ack_wait");
    chk("rd_ack", 64'(req_ack), 64'(3'b010));
    chk("rd_dout", 64'(req_dout), 64'(16'hBEEF));
    chk("rd_cs_low", 64'(p2_cs), 64'(0));
    req = '0;
    repeat (2) step();

    // single write from requester 0
    fix_dout = 16'h1234;
    req_we[0] = 1'b1; req_din[15:0] = 16'hA55A; req_ds[1:0] = 2'b01;
    req_addr[21:0] = 22'h3ABCDE;
    req = 3'b001;
    step();
    chk("wr_din", 64'(p2_din), 64'(16'hA55A));
    chk("wr_ds", 64'(p2_ds), 64'(2'b01));
    chk("wr_we", 64'(p2_we), 64'(1));
    wait_ack("wr_ack_wait");
    chk("wr_ack", 64'(req_ack), 64'(3'b001));
    chk("wr_dout_hold", 64'(req_dout), 64'(16'hBEEF));
    req = '0;
    repeat (2) step();

    // ack polarity: p2_ack is 1 at grant, plus idle toggles
    p2_ack = ~p2_ack;
    repeat (3) step();
    if (!p2_ack) p2_ack = 1'b1;
    repeat (2) step();
    chk("idle_toggle_noack", 64'(req_ack), 64'(0));
    fix_dout = 16'hC0DE;
    req_we[2] = 1'b0;
    req = 3'b100;
    step();
    chk("pol_cs", 64'(p2_cs), 64'(1));
    wait_ack("pol_ack_wait");
    chk("pol_ack", 64'(req_ack), 64'(3'b100));
    chk("pol_dout", 64'(req_dout), 64'(16'hC0DE));
    req = '0;
    p2_ack = ~p2_ack;
    repeat (4) step();
    chk("idle_toggle_noack2", 64'(req_ack), 64'(0));

    // round-robin under continuous requests
    ack_log.delete();
    req = 3'b111;
    rr_on = 1;
    tcnt = 0;
    while (ack_log.size() < 6 && tcnt < 300) begin
      step();
      tcnt++;
    end
    rr_on = 0;
    chk("rr_count_ok", 64'(ack_log.size() >= 6), 64'(1));
    for (int k = 0; k < 6 && k < ack_log.size(); k++) chk("rr_order", 64'(ack_log[k]), 64'(rr_exp[k]));
    drain();

    // reset mid-WAIT
    resp_en = 0;
    req = 3'b001;
    step();
    repeat (2) step();
    chk("mid_cs_before", 64'(p2_cs), 64'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", 64'(p2_cs), 64'(0));
    chk("mid_rst_ack", 64'(req_ack), 64'(0));
    chk("mid_rst_err", 64'(req_err), 64'(0));
    p2_ack = ~p2_ack;
    step();
    reset = 1'b0;
    resp_en = 1;
    resp_delay = 3;
    step();
    chk("post_rst_cs", 64'(p2_cs), 64'(1));
    wait_ack("post_rst_ack_wait");
    chk("post_rst_ack", 64'(req_ack), 64'(3'b001));
    req = '0;
    repeat (2) step();

`ifdef ARB_TIMEOUT_EN
    resp_en = 0;
    req = 3'b010;
    step();
    tcnt = 0;
    while (p2_cs && tcnt < 100) begin
      step();
      tcnt++;
    end
    chk("to_len", 64'(tcnt), 64'(TO));
    chk("to_ack", 64'(req_ack), 64'(3'b010));
    chk("to_err", 64'(req_err), 64'(3'b010));
    req = '0;
    resp_en = 1;
    repeat (2) step();
    req = 3'b100;
    step();
    wait_ack("after_to_ack_wait");
    chk("after_to_ack", 64'(req_ack), 64'(3'b100));
    chk("after_to_err", 64'(req_err), 64'(0));
    req = '0;
    repeat (2) step();
`endif

    // randomized traffic
    fix_dout_en = 0;
    resp_delay = $urandom_range(1, 8);
    rand_on = 1;
    repeat (3000) step();
    rand_on = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
